// File: rtl/gba_pad_pkg.sv
// Shared types and constants for the GBA pad scanner: FSM states, serial bit
// positions of the pad frame and the default timing parameters.
package gba_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_READ_LO,
    ST_READ_HI,
    ST_DONE
  } state_t;

  localparam int BIT_B      = 0;
  localparam int BIT_Y      = 1;
  localparam int BIT_SELECT = 2;
  localparam int BIT_START  = 3;
  localparam int BIT_UP     = 4;
  localparam int BIT_DOWN   = 5;
  localparam int BIT_LEFT   = 6;
  localparam int BIT_RIGHT  = 7;
  localparam int BIT_A      = 8;
  localparam int BIT_X      = 9;
  localparam int BIT_L      = 10;
  localparam int BIT_R      = 11;
  localparam int BIT_ID0    = 12;
  localparam int BIT_ID1    = 13;
  localparam int BIT_ID2    = 14;
  localparam int BIT_ID3    = 15;

  localparam int CLK_DIV_DEFAULT     = 100;
  localparam int POLL_PERIOD_DEFAULT = 279620;
  localparam int NUM_KEYS            = 10;

  // Key vector order: {L, R, Down, Up, Left, Right, Start, Select, B, A}
  function automatic logic [NUM_KEYS-1:0] map_keys(input logic [15:0] b);
    map_keys = {b[BIT_L], b[BIT_R], b[BIT_DOWN], b[BIT_UP], b[BIT_LEFT],
                b[BIT_RIGHT], b[BIT_START], b[BIT_SELECT], b[BIT_B], b[BIT_A]};
  endfunction

endpackage

// File: rtl/gba_sync2.sv
// Generic two-flop synchronizer with synchronous active-low reset to zero.
module gba_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gba_pad_scanner.sv
// Periodic / on-demand serial pad scanner: latches the pad, shifts 16 bits in,
// publishes the raw frame and per-key debounced button states.
module gba_pad_scanner
  import gba_pad_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEFAULT,
  parameter int POLL_PERIOD = POLL_PERIOD_DEFAULT
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        scan_req,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic        KeyA,
  output logic        KeyB,
  output logic        KeySelect,
  output logic        KeyStart,
  output logic        KeyRight,
  output logic        KeyLeft,
  output logic        KeyUp,
  output logic        KeyDown,
  output logic        KeyR,
  output logic        KeyL,
  output logic [15:0] raw_bits,
  output logic        pad_present,
  output logic        scan_done,
  output logic        busy
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int TW = $clog2(POLL_PERIOD + 1);

  state_t              state, next_state;
  logic [CW-1:0]       cnt;
  logic [3:0]          bit_idx;
  logic [15:0]         shift;
  logic [TW-1:0]       poll_timer;
  logic                pending;
  logic [NUM_KEYS-1:0] keys, hist, cur_keys, stable;
  logic                pad_sync, phase_last, start, id_ok;
  logic                latch_d, clk_d, busy_d, done_d;

  gba_sync2 #(.W(1)) u_sync (
    .clk   (mclk),
    .rst_n (rst_n),
    .d     (pad_data),
    .q     (pad_sync)
  );

  assign start    = (scan_en && poll_timer == '0) || pending || scan_req;
  assign cur_keys = map_keys(shift);
  assign stable   = ~(cur_keys ^ hist);
  assign id_ok    = (shift[BIT_ID3:BIT_ID0] == 4'b0000);

  always_comb begin
    phase_last = 1'b0;
    case (state)
      ST_LATCH:               phase_last = (cnt == CW'(2 * CLK_DIV - 1));
      ST_READ_LO, ST_READ_HI: phase_last = (cnt == CW'(CLK_DIV - 1));
      default:                phase_last = 1'b0;
    endcase
  end

  // State register; pad strobes and status flags are registered from next_state
  // so they line up exactly with the state they describe.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= next_state;
      pad_latch <= latch_d;
      pad_clk   <= clk_d;
      busy      <= busy_d;
      scan_done <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_LATCH;
      ST_LATCH:   if (phase_last) next_state = ST_READ_LO;
      ST_READ_LO: if (phase_last) next_state = ST_READ_HI;
      ST_READ_HI: if (phase_last) next_state = (bit_idx == 4'(BIT_ID3)) ? ST_DONE : ST_READ_LO;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_d = (next_state == ST_LATCH);
    clk_d   = (next_state != ST_READ_LO);
    busy_d  = (next_state != ST_IDLE);
    done_d  = (next_state == ST_DONE);
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      poll_timer  <= '0;
      pending     <= 1'b0;
      raw_bits    <= '0;
      pad_present <= 1'b0;
      keys        <= '0;
      hist        <= '0;
    end else begin
      if (next_state != state) cnt <= '0;
      else if (state != ST_IDLE) cnt <= cnt + 1'b1;

      if (state == ST_LATCH) bit_idx <= '0;
      else if (state == ST_READ_HI && phase_last) bit_idx <= bit_idx + 1'b1;

      // Pad lines are active-low; store 1 = pressed.
      if (state == ST_READ_LO && phase_last) shift[bit_idx] <= ~pad_sync;

      if (state == ST_IDLE && next_state == ST_LATCH) poll_timer <= TW'(POLL_PERIOD - 1);
      else if (poll_timer != '0) poll_timer <= poll_timer - 1'b1;

      if (state == ST_IDLE && next_state == ST_LATCH) pending <= 1'b0;
      else if (scan_req && state != ST_IDLE) pending <= 1'b1;

      // A key follows its bit only once two consecutive scans agree on it.
      if (state == ST_DONE) begin
        raw_bits    <= shift;
        pad_present <= id_ok;
        hist        <= cur_keys;
        if (!id_ok) keys <= '0;
        else keys <= (keys & ~stable) | (cur_keys & stable);
      end
    end
  end

  assign KeyA      = keys[0];
  assign KeyB      = keys[1];
  assign KeySelect = keys[2];
  assign KeyStart  = keys[3];
  assign KeyRight  = keys[4];
  assign KeyLeft   = keys[5];
  assign KeyUp     = keys[6];
  assign KeyDown   = keys[7];
  assign KeyR      = keys[8];
  assign KeyL      = keys[9];

endmodule

// File: tb/tb_gba_pad_scanner.sv
// Directed and randomized bench for gba_pad_scanner with a serial pad model and
// a scan-level reference model of raw frame, ID check and per-key debounce.
module tb_gba_pad_scanner;

  localparam int CLK_DIV     = 2;
  localparam int POLL_PERIOD = 200;
  localparam int SCAN_LEN    = 34 * CLK_DIV + 1;
  localparam int LATCH_LEN   = 2 * CLK_DIV;

  logic        mclk = 1'b0;
  logic        rst_n, scan_en, scan_req, pad_data;
  logic        pad_latch, pad_clk;
  logic        KeyA, KeyB, KeySelect, KeyStart, KeyRight, KeyLeft, KeyUp, KeyDown, KeyR, KeyL;
  logic [15:0] raw_bits;
  logic        pad_present, scan_done, busy;
  logic [9:0]  key_vec;

  logic [15:0] pad_btn = 16'h0000;
  logic [15:0] pad_sr  = 16'h0000;
  logic        no_pad  = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [9:0]  m_hist, exp_keys;
  logic [15:0] exp_raw;
  logic        exp_present;

  always #5 mclk = ~mclk;

  gba_pad_scanner #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD)) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .scan_req    (scan_req),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .KeyA        (KeyA),
    .KeyB        (KeyB),
    .KeySelect   (KeySelect),
    .KeyStart    (KeyStart),
    .KeyRight    (KeyRight),
    .KeyLeft     (KeyLeft),
    .KeyUp       (KeyUp),
    .KeyDown     (KeyDown),
    .KeyR        (KeyR),
    .KeyL        (KeyL),
    .raw_bits    (raw_bits),
    .pad_present (pad_present),
    .scan_done   (scan_done),
    .busy        (busy)
  );

  assign key_vec = {KeyL, KeyR, KeyDown, KeyUp, KeyLeft, KeyRight, KeyStart, KeySelect, KeyB, KeyA};

  // Pad: latch loads the buttons, each pad_clk rise presents the next one.
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_sr <= pad_btn;
    else pad_sr <= {1'b0, pad_sr[15:1]};
  end
  assign pad_data = no_pad ? 1'b0 : ~pad_sr[0];

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model_map(input logic [15:0] b);
    logic [9:0] k;
    k[0] = b[8];  k[1] = b[0];  k[2] = b[2];  k[3] = b[3];  k[4] = b[7];
    k[5] = b[6];  k[6] = b[4];  k[7] = b[5];  k[8] = b[11]; k[9] = b[10];
    return k;
  endfunction

  task automatic model_reset();
    m_hist   = '0;
    exp_keys = '0;
  endtask

  task automatic model_scan(input logic [15:0] b);
    logic [9:0] cur;
    cur         = model_map(b);
    exp_raw     = b;
    exp_present = (b[15:12] == 4'h0);
    for (int i = 0; i < 10; i++) begin
      if (!exp_present) exp_keys[i] = 1'b0;
      else if (cur[i] == m_hist[i]) exp_keys[i] = cur[i];
    end
    m_hist = cur;
  endtask

  task automatic wait_busy(input int budget, output int waited);
    waited = 0;
    while (busy !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic measure_scan(input int req_a, input int req_b, input int en_off_at, input int rst_at,
                              output int busy_len, output int latch_len,
                              output int done_pos, output int done_cnt);
    busy_len = 0; latch_len = 0; done_pos = 0; done_cnt = 0;
    while (busy === 1'b1 && busy_len < 200) begin
      busy_len++;
      if (pad_latch === 1'b1) latch_len++;
      if (scan_done === 1'b1) begin
        done_cnt++;
        done_pos = busy_len;
      end
      scan_req = (busy_len == req_a || busy_len == req_b);
      if (busy_len == en_off_at) scan_en = 1'b0;
      if (busy_len == rst_at) rst_n = 1'b0;
      tick();
    end
    scan_req = 1'b0;
  endtask

  task automatic check_scan(input string tag, input logic [15:0] b, input int busy_len,
                            input int latch_len, input int done_pos, input int done_cnt);
    model_scan(b);
    check({tag, "_busy_len"}, busy_len, SCAN_LEN);
    check({tag, "_latch_len"}, latch_len, LATCH_LEN);
    check({tag, "_done_pos"}, done_pos, SCAN_LEN);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_raw"}, raw_bits, exp_raw);
    check({tag, "_present"}, pad_present, exp_present);
    check({tag, "_keys"}, key_vec, exp_keys);
  endtask

  task automatic apply_reset(input logic en);
    rst_n = 1'b0; scan_en = en; scan_req = 1'b0;
    repeat (3) tick();
    model_reset();
  endtask

  initial begin
    int bl, ll, dp, dc, w;
    logic [15:0] b;
    int first_start, periods;

    // Power-on reset and first periodic scans.
    pad_btn = 16'h0101;
    apply_reset(1'b1);
    check("rst_pad_clk", pad_clk, 1);
    check("rst_pad_latch", pad_latch, 0);
    check("rst_busy", busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_raw", raw_bits, 0);
    check("rst_present", pad_present, 0);
    check("rst_keys", key_vec, 0);
    rst_n = 1'b1;
    tick();
    check("s1_latch_first_cycle", pad_latch, 1);
    check("s1_busy_first_cycle", busy, 1);
    measure_scan(0, 0, 0, 0, bl, ll, dp, dc);
    check_scan("s1_scan1", 16'h0101, bl, ll, dp, dc);
    check("s1_keys_after_first", key_vec, 0);
    wait_busy(400, w);
    check("s1_second_start", busy, 1);
    check("s1_poll_period", bl + w, POLL_PERIOD);
    measure_scan(0, 0, 0, 0, bl, ll, dp, dc);
    check_scan("s1_scan2", 16'h0101, bl, ll, dp, dc);
    check("s1_keyA", KeyA, 1);
    check("s1_keyB", KeyB, 1);

    // Alternating A / A+B: only A is stable.
    apply_reset(1'b1);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      b = (n % 2 == 0) ? 16'h0100 : 16'h0101;
      pad_btn = b;
      wait_busy(400, w);
      check("s2_start", busy, 1);
      measure_scan(0, 0, 0, 0, bl, ll, dp, dc);
      check_scan("s2_alt", b, bl, ll, dp, dc);
      check("s2_keyB_low", KeyB, 0);
    end
    check("s2_keyA_high", KeyA, 1);

    // No pad connected: data line held low.
    no_pad = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_busy(400, w);
      check("s3_start", busy, 1);
      measure_scan(0, 0, 0, 0, bl, ll, dp, dc);
      check_scan("s3_nopad", 16'hFFFF, bl, ll, dp, dc);
    end
    no_pad = 1'b0;

    // Randomized button frames, with repeats and occasional bad ID.
    b = 16'h0000;
    for (int n = 0; n < 8; n++) begin
      if (n == 0 || $urandom_range(0, 1) == 0) begin
        b = 16'($urandom_range(0, 4095));
        if ($urandom_range(0, 3) == 0) b[15:12] = 4'($urandom_range(1, 15));
      end
      pad_btn = b;
      wait_busy(400, w);
      check("rnd_start", busy, 1);
      measure_scan(0, 0, 0, 0, bl, ll, dp, dc);
      check_scan("rnd_scan", b, bl, ll, dp, dc);
    end

    // Requests with polling disabled.
    pad_btn = 16'h0008;
    apply_reset(1'b0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("s4_idle_no_poll", busy, 0);
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    check("s4_req_next_cycle", busy, 1);
    measure_scan(10, 40, 0, 0, bl, ll, dp, dc);
    check_scan("s4_req_scan", 16'h0008, bl, ll, dp, dc);
    check("s4_idle_after_done", busy, 0);
    wait_busy(50, w);
    check("s4_pending_start", busy, 1);
    check("s4_pending_gap", w, 1);
    measure_scan(0, 0, 0, 0, bl, ll, dp, dc);
    check_scan("s4_pending_scan", 16'h0008, bl, ll, dp, dc);
    check("s4_keyStart", KeyStart, 1);
    wait_busy(500, w);
    check("s4_no_further_scan", busy, 0);

    // Request coincides with an expired poll timer: one scan only.
    pad_btn = 16'h0010;
    apply_reset(1'b1);
    rst_n = 1'b1;
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    check("s5_merge_start", busy, 1);
    first_start = 0;
    measure_scan(0, 0, 0, 0, bl, ll, dp, dc);
    check_scan("s5_merge_scan", 16'h0010, bl, ll, dp, dc);
    wait_busy(400, w);
    periods = first_start + bl + w;
    check("s5_merge_period", periods, POLL_PERIOD);

    // Reset mid-scan aborts without a partial update.
    apply_reset(1'b1);
    rst_n = 1'b1;
    tick();
    check("s6_start", busy, 1);
    measure_scan(0, 0, 0, 30, bl, ll, dp, dc);
    check("s6_abort_len", bl, 30);
    check("s6_pad_clk", pad_clk, 1);
    check("s6_pad_latch", pad_latch, 0);
    check("s6_busy", busy, 0);
    check("s6_raw", raw_bits, 0);
    check("s6_no_done", dc, 0);
    tick();
    check("s6_no_done_in_reset", scan_done, 0);
    model_reset();

    // Clearing scan_en mid-scan lets the scan finish, then polling stops.
    pad_btn = 16'h0C00;
    rst_n = 1'b1;
    tick();
    check("s7_start", busy, 1);
    measure_scan(0, 0, 10, 0, bl, ll, dp, dc);
    check_scan("s7_en_off", 16'h0C00, bl, ll, dp, dc);
    wait_busy(500, w);
    check("s7_no_new_scan", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gba_pad_scanner.md
GBA_PAD_SCANNER -- requirements
Module: gba_pad_scanner

Interface
REQ-001 Parameter CLK_DIV, default 100: mclk cycles per half-period of pad_clk (legal range 1 to 4095).
REQ-002 Parameter POLL_PERIOD, default 279620: mclk cycles from one scan start to the next (about 60 Hz at 16.78 MHz); must be at least 34*CLK_DIV+2.
REQ-003 Port mclk  input  1  sole clock; all state on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port scan_en  input  1  enables periodic polling.
REQ-006 Port scan_req  input  1  single-cycle request for an immediate scan.
REQ-007 Port pad_data  input  1  serial data from the pad, asynchronous, active-low per button.
REQ-008 Port pad_latch  output  1  latch strobe to the pad.
REQ-009 Port pad_clk  output  1  shift clock to the pad; idles high.
REQ-010 Ports KeyA, KeyB, KeySelect, KeyStart, KeyRight, KeyLeft, KeyUp, KeyDown, KeyR, KeyL  output  1 each  debounced button state, 1 = pressed; these drive the matching inputs of gba_joypad.
REQ-011 Port raw_bits  output  16  last completed scan in pad order, 1 = pressed.
REQ-012 Port pad_present  output  1  last scan ID nibble was valid.
REQ-013 Port scan_done  output  1  one-cycle pulse when a scan completes.
REQ-014 Port busy  output  1  high from the LATCH state through the DONE state inclusive.

Function
REQ-015 pad_data SHALL pass through the 2-flop synchronizer before use.
REQ-016 States: IDLE, LATCH, READ_LO, READ_HI, DONE.
- IDLE->LATCH when a start condition is true.
- LATCH lasts 2*CLK_DIV cycles.
- READ_LO and READ_HI each last CLK_DIV cycles per bit, for 16 bits (bit index 0..15).
- After bit 15 READ_HI -> DONE for 1 cycle -> IDLE.
- Total scan length = 34*CLK_DIV+1 cycles.
REQ-017 pad_latch SHALL be 1 only in LATCH; pad_clk SHALL be 0 only in READ_LO. Both outputs are registered.
REQ-018 Sampling: in the last cycle of each READ_LO, the synchronized pad_data is inverted and stored at the current bit index.
- Bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12-15 ID.
REQ-019 Start condition is (scan_en and poll timer expired) or a pending request. The poll timer reloads to POLL_PERIOD-1 on entering LATCH and saturates at 0.
REQ-020 Request handling:
- scan_req in IDLE starts a scan on the next cycle.
- scan_req while busy sets a single pending flag, consumed by one scan after DONE; multiple requests merge.
- Simultaneous timer expiry and request yield exactly one scan.
REQ-021 In DONE:
- raw_bits <= shift register.
- pad_present <= (bits 15:12 == 4'b0000), i.e. ID lines read high.
- scan_done = 1.
REQ-022 Debounce: Key* outputs update in DONE only when the current 10 mapped bits equal those of the previous completed scan. If pad_present is 0, all Key* are forced to 0 in that DONE cycle.
REQ-023 Mapping: KeyA=bit8, KeyB=bit0, KeySelect=bit2, KeyStart=bit3, KeyRight=bit7, KeyLeft=bit6, KeyUp=bit4, KeyDown=bit5, KeyR=bit11, KeyL=bit10.
REQ-024 Clearing scan_en mid-scan SHALL NOT abort the scan in progress.

Reset
REQ-025 While rst_n=0, on each mclk edge:
- state=IDLE.
- pad_latch=0, pad_clk=1.
- All Key*, raw_bits, pad_present, scan_done and busy = 0.
- Pending flag, debounce history and synchronizer cleared.
- Poll timer = 0 (expired).
REQ-026 Reset asserted mid-scan SHALL abort the scan with no partial update. If scan_en=1, the first scan enters LATCH on the first cycle after rst_n returns high.

Structure
REQ-027 Package gba_pad_pkg holds:
- the state enum;
- the 16 bit-index constants;
- the CLK_DIV and POLL_PERIOD defaults.
REQ-028 The one sub-module is gba_sync2 (generic 2-flop synchronizer with reset). Everything else is one module, about 200 lines.

Verification
All scenarios use CLK_DIV=2, POLL_PERIOD=200, and a pad model that shifts on the pad_clk rising edge.
REQ-029 Release reset with scan_en=1 and pad bits = 16'h0101 pressed plus an ID nibble reading high:
- LATCH holds for 4 cycles and busy holds for 69 cycles;
- scan_done at cycle 69;
- raw_bits = 16'h0101 and pad_present = 1;
- Key* stay 0 until the second identical scan, which starts at cycle 200; KeyA=1 and KeyB=1 from that scan's DONE.
REQ-030 Alternate scans between A and A+B pressed -> KeyB never rises; KeyA rises after the second scan.
REQ-031 Hold pad_data low (no pad) -> raw_bits = 16'hFFFF, pad_present = 0, all Key* = 0.
REQ-032 Pulse scan_req twice during busy with scan_en=0 -> exactly one extra scan starts the cycle after DONE, and no further scans follow.
REQ-033 Drop rst_n at cycle 30 of a scan -> next cycle pad_clk=1, pad_latch=0, busy=0; raw_bits unchanged at 0; no scan_done.
REQ-034 Deassert scan_en mid-scan -> the scan completes normally (scan_done pulses) and no new scan starts.
